// File: rtl/axi_mux_switch_ctrl_pkg.sv
// Shared types for the AXI mux safe-switch controller.
//   SoftRegReq / SoftRegResp : soft-register request and read response
//   axi_req_t / axi_rsp_t    : AXI bus split by direction
//                              (req = master->slave, rsp = slave->master)
//   sw_state_e               : switch FSM states
//   STAT_*                   : status word bit layout
package axi_mux_switch_ctrl_pkg;

  localparam int unsigned SR_ADDR_W = 32;
  localparam int unsigned SR_DATA_W = 64;

  typedef struct packed {
    logic                 valid;
    logic                 isWrite;
    logic [SR_ADDR_W-1:0] addr;
    logic [SR_DATA_W-1:0] data;
  } SoftRegReq;

  typedef struct packed {
    logic                 valid;
    logic [SR_DATA_W-1:0] data;
  } SoftRegResp;

  typedef struct packed {
    logic        arvalid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [3:0]  arid;
    logic        rready;
    logic        awvalid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [3:0]  awid;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bready;
  } axi_req_t;

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        awready;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic [3:0]  bid;
  } axi_rsp_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_SWITCH = 2'd2,
    ST_SETTLE = 2'd3
  } sw_state_e;

  localparam int unsigned STAT_SEL  = 0;
  localparam int unsigned STAT_BUSY = 1;
  localparam int unsigned STAT_PEND = 2;

  function automatic logic [SR_DATA_W-1:0] pack_status(input logic pend,
                                                       input logic bsy,
                                                       input logic sl);
    logic [SR_DATA_W-1:0] d;
    d            = '0;
    d[STAT_PEND] = pend;
    d[STAT_BUSY] = bsy;
    d[STAT_SEL]  = sl;
    return d;
  endfunction

endpackage

// File: rtl/axi_mux_switch_ctrl_outstanding_ctr.sv
// Saturating up/down counter of outstanding AXI transactions.
//   clk, rst : clock, async active-low reset
//   inc, dec : count up / down this cycle (both together = no change)
//   cnt      : current count
//   zero     : cnt == 0
//   full     : cnt at maximum; the owner must stop issuing increments
module axi_mux_switch_ctrl_outstanding_ctr
  import axi_mux_switch_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             full
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // Never wraps: increments at max and decrements at zero are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (inc && !dec && !full) begin
      r_cnt <= r_cnt + C_ONE;
    end else if (dec && !inc && !zero) begin
      r_cnt <= r_cnt - C_ONE;
    end
  end

  assign cnt  = r_cnt;
  assign zero = (r_cnt == '0);
  assign full = (r_cnt == '1);

endmodule

// File: rtl/axi_mux_switch_ctrl.sv
// Safe-switch controller for a two-way AXI mux. Sits between the mux output
// and the downstream slave and owns the mux select. A soft-register write
// requests a new select; new AR/AW issue is stopped, outstanding reads and
// writes drain, sel flips, a settle window passes, then the bus reopens.
//   clk, rst          : clock, async active-low reset
//   sr_req / sr_resp  : soft register (write = target sel, read = status)
//   axi_up_req/_rsp   : upstream side, facing the mux output
//   axi_dn_req/_rsp   : downstream side, facing the slave
//   sel               : mux select
//   busy              : high whenever the FSM is not in RUN
//
// state     | meaning
// ----------+-------------------------------------------------
// ST_RUN    | bus open, waiting for a select request
// ST_DRAIN  | AR/AW closed, waiting for all counters to reach 0
// ST_SWITCH | one cycle, sel <- target on exit
// ST_SETTLE | gate held closed for SETTLE_CYC cycles
module axi_mux_switch_ctrl
  import axi_mux_switch_ctrl_pkg::*;
#(
  parameter logic [SR_ADDR_W-1:0] SR_ADDR    = 'h10,
  parameter int unsigned          CNT_W      = 8,
  parameter int unsigned          SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  SoftRegReq  sr_req,
  output SoftRegResp sr_resp,
  input  axi_req_t   axi_up_req,
  output axi_rsp_t   axi_up_rsp,
  output axi_req_t   axi_dn_req,
  input  axi_rsp_t   axi_dn_rsp,
  output logic       sel,
  output logic       busy
);

  localparam int unsigned     ST_W        = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [ST_W-1:0] SETTLE_LOAD = ST_W'(SETTLE_CYC - 1);
  localparam logic [ST_W-1:0] ST_ONE      = ST_W'(1);

  sw_state_e         r_state;
  logic              r_gate;
  logic              r_busy;
  logic              r_sel;
  logic              r_target;
  logic              r_pend;
  logic [ST_W-1:0]   r_settle;
  logic              r_resp_valid;
  logic [SR_DATA_W-1:0] r_resp_data;

  logic [CNT_W-1:0]  w_rd_cnt, w_wr_cnt, w_w_cnt;
  logic              w_rd_zero, w_wr_zero, w_w_zero;
  logic              w_rd_full, w_wr_full, w_w_full;
  logic              w_ar_block, w_aw_block, w_w_block;
  logic              w_ar_hs, w_r_last_hs, w_aw_hs, w_w_last_hs, w_b_hs;
  logic              w_all_zero;
  logic              w_sr_hit, w_sr_wr, w_sr_rd;
  logic              w_unused;

  // Saturation gating applies in every state so no counter can wrap.
  assign w_ar_block = r_gate | w_rd_full;
  assign w_aw_block = r_gate | w_wr_full | w_w_full;
  // While gated, W may only carry data for an AW already issued.
  assign w_w_block  = r_gate & w_w_zero;

  always_comb begin
    axi_dn_req         = axi_up_req;
    axi_dn_req.arvalid = axi_up_req.arvalid & ~w_ar_block;
    axi_dn_req.awvalid = axi_up_req.awvalid & ~w_aw_block;
    axi_dn_req.wvalid  = axi_up_req.wvalid  & ~w_w_block;
    axi_up_rsp         = axi_dn_rsp;
    axi_up_rsp.arready = axi_dn_rsp.arready & ~w_ar_block;
    axi_up_rsp.awready = axi_dn_rsp.awready & ~w_aw_block;
    axi_up_rsp.wready  = axi_dn_rsp.wready  & ~w_w_block;
  end

  assign w_ar_hs     = axi_up_req.arvalid & axi_dn_rsp.arready & ~w_ar_block;
  assign w_aw_hs     = axi_up_req.awvalid & axi_dn_rsp.awready & ~w_aw_block;
  assign w_w_last_hs = axi_up_req.wvalid  & axi_dn_rsp.wready  & ~w_w_block & axi_up_req.wlast;
  assign w_r_last_hs = axi_dn_rsp.rvalid  & axi_up_req.rready  & axi_dn_rsp.rlast;
  assign w_b_hs      = axi_dn_rsp.bvalid  & axi_up_req.bready;

  axi_mux_switch_ctrl_outstanding_ctr #(.CNT_W(CNT_W)) u_rd_ctr (
    .clk(clk), .rst(rst), .inc(w_ar_hs), .dec(w_r_last_hs),
    .cnt(w_rd_cnt), .zero(w_rd_zero), .full(w_rd_full)
  );

  axi_mux_switch_ctrl_outstanding_ctr #(.CNT_W(CNT_W)) u_wr_ctr (
    .clk(clk), .rst(rst), .inc(w_aw_hs), .dec(w_b_hs),
    .cnt(w_wr_cnt), .zero(w_wr_zero), .full(w_wr_full)
  );

  axi_mux_switch_ctrl_outstanding_ctr #(.CNT_W(CNT_W)) u_w_ctr (
    .clk(clk), .rst(rst), .inc(w_aw_hs), .dec(w_w_last_hs),
    .cnt(w_w_cnt), .zero(w_w_zero), .full(w_w_full)
  );

  assign w_all_zero = w_rd_zero & w_wr_zero & w_w_zero;

  assign w_sr_hit = sr_req.valid && (sr_req.addr == SR_ADDR);
  assign w_sr_wr  = w_sr_hit &  sr_req.isWrite;
  assign w_sr_rd  = w_sr_hit & ~sr_req.isWrite;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_RUN;
      r_gate   <= 1'b0;
      r_busy   <= 1'b0;
      r_sel    <= 1'b1;
      r_target <= 1'b1;
      r_pend   <= 1'b0;
      r_settle <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (r_pend && (r_target != r_sel)) begin
            r_state <= ST_DRAIN;
            r_gate  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (w_all_zero) r_state <= ST_SWITCH;
        end
        ST_SWITCH: begin
          r_sel    <= r_target;
          r_settle <= SETTLE_LOAD;
          r_state  <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_settle == '0) begin
            r_state <= ST_RUN;
            r_gate  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_settle <= r_settle - ST_ONE;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_gate  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase

      // A fresh write wins over the clear so a request is never lost.
      // In RUN a pending request either starts a drain or is a no-op,
      // so it is consumed either way.
      if (w_sr_wr) begin
        r_target <= sr_req.data[0];
        r_pend   <= 1'b1;
      end else if ((r_state == ST_RUN) || ((r_state == ST_DRAIN) && w_all_zero)) begin
        r_pend   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
    end else begin
      r_resp_valid <= w_sr_rd;
      if (w_sr_rd) r_resp_data <= pack_status(r_pend, r_busy, r_sel);
    end
  end

  assign sr_resp.valid = r_resp_valid;
  assign sr_resp.data  = r_resp_data;
  assign sel           = r_sel;
  assign busy          = r_busy;

  assign w_unused = ^{sr_req.data[SR_DATA_W-1:1], w_rd_cnt, w_wr_cnt, w_w_cnt};

endmodule

// File: tb/tb_axi_mux_switch_ctrl.sv
// Directed bench for axi_mux_switch_ctrl (CNT_W=2, SETTLE_CYC=2).
// The bench plays both the upstream master and the downstream slave.
module tb_axi_mux_switch_ctrl;
  import axi_mux_switch_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  SoftRegReq  sr_req;
  SoftRegResp sr_resp;
  axi_req_t   up_req, dn_req;
  axi_rsp_t   up_rsp, dn_rsp;
  logic       sel, busy;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_mux_switch_ctrl #(.SR_ADDR('h10), .CNT_W(2), .SETTLE_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .sr_req     (sr_req),
    .sr_resp    (sr_resp),
    .axi_up_req (up_req),
    .axi_up_rsp (up_rsp),
    .axi_dn_req (dn_req),
    .axi_dn_rsp (dn_rsp),
    .sel        (sel),
    .busy       (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic sr_op(input logic wr, input logic [31:0] a, input logic [63:0] d);
    sr_req.valid   = 1'b1;
    sr_req.isWrite = wr;
    sr_req.addr    = a;
    sr_req.data    = d;
    step();
    sr_req = '0;
  endtask

  task automatic slave_idle();
    dn_rsp         = '0;
    dn_rsp.arready = 1'b1;
    dn_rsp.awready = 1'b1;
    dn_rsp.wready  = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected busy/sel after edges E0..E5 following an idle-bus write of 0.
  logic [5:0] exp_busy;
  logic [5:0] exp_sel;

  initial begin
    exp_busy = 6'b011110;   // bit k = after edge Ek
    exp_sel  = 6'b000111;
    rst    = 1'b0;
    sr_req = '0;
    up_req = '0;
    up_req.rready = 1'b1;
    up_req.bready = 1'b1;
    slave_idle();

    // ---- reset values
    step(); step();
    chk("rst_sel",   sel, 1);
    chk("rst_busy",  busy, 0);
    chk("rst_rvld",  sr_resp.valid, 0);
    chk("rst_rdata", sr_resp.data, 0);
    rst = 1'b1;
    step();

    // ---- idle bus, switch 1 -> 0: sel flips on edge E3, busy E1..E4
    sr_op(1'b1, 32'h10, 64'h0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("idle_busy_%0d", k), busy, exp_busy[k]);
      chk($sformatf("idle_sel_%0d", k),  sel,  exp_sel[k]);
      step();
    end

    // ---- two AR bursts (arlen=3) outstanding, then switch 0 -> 1
    up_req.arvalid = 1'b1; up_req.arlen = 8'd3; up_req.arid = 4'd1; up_req.araddr = 32'h100;
    #1;
    chk("ar_pass_vld", dn_req.arvalid, 1);
    chk("ar_pass_id",  dn_req.arid, 1);
    step();
    up_req.arid = 4'd2; up_req.araddr = 32'h200;
    step();
    up_req.arvalid = 1'b0;
    chk("ar_rdcnt2", dut.u_rd_ctr.cnt, 2);
    sr_op(1'b1, 32'h10, 64'h1);
    step();
    up_req.arvalid = 1'b1;
    #1;
    chk("ar_gate_rdy", up_rsp.arready, 0);
    chk("ar_gate_vld", dn_req.arvalid, 0);
    up_req.arvalid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dn_rsp.rvalid = 1'b1;
      dn_rsp.rdata  = 32'hA0 + i;
      dn_rsp.rid    = (i < 4) ? 4'd1 : 4'd2;
      dn_rsp.rlast  = ((i % 4) == 3);
      #1;
      chk($sformatf("r_data_%0d", i), up_rsp.rdata, 32'hA0 + i);
      chk($sformatf("r_last_%0d", i), up_rsp.rlast, ((i % 4) == 3) ? 1 : 0);
      chk($sformatf("r_ardy_%0d", i), up_rsp.arready, 0);
      step();
    end
    dn_rsp.rvalid = 1'b0; dn_rsp.rlast = 1'b0;
    chk("rd_drain_busy", busy, 1);
    chk("rd_drain_sel",  sel, 0);
    step();
    chk("rd_switch_sel", sel, 0);
    step();
    chk("rd_flip_sel",   sel, 1);
    step();
    chk("rd_settle_busy", busy, 1);
    step();
    chk("rd_done_busy",  busy, 0);
    chk("rd_open_ardy",  up_rsp.arready, 1);

    // ---- write 0 then retarget to 1 during DRAIN: no flip
    up_req.arvalid = 1'b1; up_req.arlen = 8'd0; up_req.arid = 4'd3;
    step();
    up_req.arvalid = 1'b0;
    sr_op(1'b1, 32'h10, 64'h0);
    step();
    chk("rt_drain_busy", busy, 1);
    sr_op(1'b1, 32'h10, 64'h1);
    step();
    sr_op(1'b0, 32'h10, 64'h0);
    chk("rt_stat_vld",  sr_resp.valid, 1);
    chk("rt_stat_data", sr_resp.data, 64'h7);
    step();
    chk("rt_stat_pulse", sr_resp.valid, 0);
    sr_op(1'b0, 32'h14, 64'h0);
    chk("rt_other_addr", sr_resp.valid, 0);
    dn_rsp.rvalid = 1'b1; dn_rsp.rlast = 1'b1; dn_rsp.rid = 4'd3;
    step();
    dn_rsp.rvalid = 1'b0; dn_rsp.rlast = 1'b0;
    step();
    step();
    chk("rt_sel_hold",   sel, 1);
    chk("rt_settle_busy", busy, 1);
    step();
    step();
    chk("rt_done_busy",  busy, 0);
    sr_op(1'b0, 32'h10, 64'h0);
    chk("rt_final_stat", sr_resp.data, 64'h1);

    // ---- AW accepted, W stalled, then switch 1 -> 0
    dn_rsp.wready  = 1'b0;
    up_req.awvalid = 1'b1; up_req.awlen = 8'd1; up_req.awid = 4'd5;
    #1;
    chk("aw_pass_vld", dn_req.awvalid, 1);
    step();
    up_req.awvalid = 1'b0;
    up_req.wvalid  = 1'b1; up_req.wdata = 32'hD0; up_req.wlast = 1'b0; up_req.wstrb = 4'hF;
    sr_op(1'b1, 32'h10, 64'h0);
    step();
    chk("w_drain_busy", busy, 1);
    dn_rsp.wready = 1'b1;
    #1;
    chk("w_drain_rdy",  up_rsp.wready, 1);
    chk("w_drain_vld",  dn_req.wvalid, 1);
    chk("w_drain_data", dn_req.wdata, 32'hD0);
    step();
    up_req.wdata = 32'hD1; up_req.wlast = 1'b1;
    #1;
    chk("wlast_vld",  dn_req.wvalid, 1);
    chk("wlast_last", dn_req.wlast, 1);
    step();
    up_req.wdata = 32'hD2; up_req.wlast = 1'b0;
    #1;
    chk("w_lead_vld", dn_req.wvalid, 0);
    chk("w_lead_rdy", up_rsp.wready, 0);
    up_req.wvalid = 1'b0;
    step(); step();
    chk("w_wait_sel",  sel, 1);
    chk("w_wait_busy", busy, 1);
    dn_rsp.bvalid = 1'b1; dn_rsp.bid = 4'd5;
    #1;
    chk("b_pass_vld", up_rsp.bvalid, 1);
    chk("b_pass_id",  up_rsp.bid, 5);
    step();
    dn_rsp.bvalid = 1'b0;
    chk("b_drain_sel", sel, 1);
    step();
    chk("b_switch_sel", sel, 1);
    step();
    chk("b_flip_sel", sel, 0);
    step(); step();
    chk("b_done_busy", busy, 0);

    // ---- CNT_W=2 read saturation: 4th AR blocked, count stays 3
    up_req.arvalid = 1'b1; up_req.arlen = 8'd0; up_req.arid = 4'd6;
    step(); step(); step();
    #1;
    chk("sat_ar_rdy", up_rsp.arready, 0);
    chk("sat_ar_vld", dn_req.arvalid, 0);
    chk("sat_rdcnt",  dut.u_rd_ctr.cnt, 3);
    step();
    chk("sat_rdcnt_hold", dut.u_rd_ctr.cnt, 3);
    chk("sat_busy",       busy, 0);
    up_req.arvalid = 1'b0;
    dn_rsp.rvalid = 1'b1; dn_rsp.rlast = 1'b1; dn_rsp.rid = 4'd6;
    step(); step(); step();
    dn_rsp.rvalid = 1'b0; dn_rsp.rlast = 1'b0;
    chk("sat_rdcnt_zero", dut.u_rd_ctr.cnt, 0);

    // ---- write saturation, then reset mid-DRAIN
    up_req.awvalid = 1'b1; up_req.awlen = 8'd0; up_req.awid = 4'd7;
    step(); step(); step();
    #1;
    chk("sat_aw_rdy", up_rsp.awready, 0);
    chk("sat_aw_vld", dn_req.awvalid, 0);
    up_req.awvalid = 1'b0;
    sr_op(1'b1, 32'h10, 64'h1);
    step();
    chk("rstd_busy_pre", busy, 1);
    chk("rstd_sel_pre",  sel, 0);
    rst = 1'b0;
    dn_rsp = '0;
    #1;
    chk("rstd_busy", busy, 0);
    chk("rstd_sel",  sel, 1);
    step();
    slave_idle();
    rst = 1'b1;
    step();
    chk("rstd_rdcnt", dut.u_rd_ctr.cnt, 0);
    chk("rstd_wrcnt", dut.u_wr_ctr.cnt, 0);
    chk("rstd_wcnt",  dut.u_w_ctr.cnt, 0);
    chk("rstd_busy_post", busy, 0);
    chk("rstd_sel_post",  sel, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
